// File: rtl/rf_writeback_unit.sv
// rf_writeback_unit: register-file write master merging ALU results with FIFO-buffered long-latency results plus a pending-write scoreboard.
// Define RF_WB_PERF_EN to add saturating stall/backpressure counters.
module rf_writeback_unit #(
    parameter int N     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         alu_valid,
    input  logic [4:0]   alu_rd,
    input  logic [N-1:0] alu_data,
    input  logic         lu_valid,
    input  logic [4:0]   lu_rd,
    input  logic [N-1:0] lu_data,
    output logic         lu_ready,
    input  logic         iss_valid,
    input  logic [4:0]   iss_rd,
    input  logic [4:0]   chk_rs1,
    input  logic [4:0]   chk_rs2,
    input  logic [4:0]   chk_rd,
    output logic         stall,
    output logic [31:0]  pend,
`ifdef RF_WB_PERF_EN
    output logic [31:0]  perf_stall_cnt,
    output logic [31:0]  perf_bp_cnt,
`endif
    output logic         regWrite,
    output logic [4:0]   write_reg,
    output logic [N-1:0] write_data
);
    localparam int AW = $clog2(DEPTH);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [N-1:0]  r_mem_data [DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pend;
    logic          r_we;
    logic [4:0]    r_wreg;
    logic [N-1:0]  r_wdata;
    logic          w_push, w_pop, w_full, w_empty;
    logic [4:0]    w_head_rd;
    logic [N-1:0]  w_head_data;
    logic [31:0]   w_set, w_clr;

    assign w_full      = r_count == (AW+1)'(DEPTH);
    assign w_empty     = r_count == '0;
    assign lu_ready    = !rst && !w_full;
    assign w_push      = lu_valid && lu_ready;
    // ALU results always win; the FIFO only drains on ALU-idle cycles
    assign w_pop       = !alu_valid && !w_empty;
    assign w_head_rd   = r_mem_rd[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];
    assign w_set       = iss_valid ? (32'd1 << iss_rd) : '0;
    assign w_clr       = w_pop ? (32'd1 << w_head_rd) : '0;
    assign pend        = r_pend;
    assign stall       = r_pend[chk_rs1] | r_pend[chk_rs2] | r_pend[chk_rd];
    assign regWrite    = r_we;
    assign write_reg   = r_wreg;
    assign write_data  = r_wdata;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wr_ptr]   <= lu_rd;
            r_mem_data[r_wr_ptr] <= lu_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_pend   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            // set applied after clear so a same-register re-issue stays pending
            r_pend  <= ((r_pend & ~w_clr) | w_set) & ~32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= alu_valid ? (alu_rd != '0) : (w_pop && w_head_rd != '0);
            if (alu_valid || w_pop) begin
                r_wreg  <= alu_valid ? alu_rd : w_head_rd;
                r_wdata <= alu_valid ? alu_data : w_head_data;
            end
        end
    end

`ifdef RF_WB_PERF_EN
    logic [31:0] r_stall_cnt, r_bp_cnt;

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_bp_cnt    = r_bp_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_bp_cnt    <= '0;
        end else begin
            if (stall && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (lu_valid && !lu_ready && r_bp_cnt != '1) r_bp_cnt <= r_bp_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb_rf_writeback_unit: directed stimulus with a reference FIFO model feeding an expected-write queue.
module tb_rf_writeback_unit;
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lu_valid, iss_valid;
    logic [4:0]  alu_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd;
    logic [31:0] alu_data, lu_data;
    logic        lu_ready, stall, regWrite;
    logic [31:0] pend, write_data;
    logic [4:0]  write_reg;
`ifdef RF_WB_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bp_cnt;
`endif

    int  n_assert = 0;
    int  n_fail = 0;
    int  k;
    bit  acc;
    bit  m_ready;
    wb_t exp_q[$];
    wb_t lq[$];
    wb_t e_m, e_c;

    rf_writeback_unit #(.N(32), .DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .stall(stall), .pend(pend),
`ifdef RF_WB_PERF_EN
        .perf_stall_cnt(perf_stall_cnt), .perf_bp_cnt(perf_bp_cnt),
`endif
        .regWrite(regWrite), .write_reg(write_reg), .write_data(write_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: ALU has priority, FIFO drains when ALU idle, x0 writes dropped
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            lq.delete();
        end else begin
            m_ready = lq.size() < 4;
            if (alu_valid) begin
                if (alu_rd != 0) exp_q.push_back('{alu_rd, alu_data});
            end else if (lq.size() > 0) begin
                e_m = lq.pop_front();
                if (e_m.rd != 0) exp_q.push_back(e_m);
            end
            if (lu_valid && m_ready) lq.push_back('{lu_rd, lu_data});
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("lu_ready_model", lu_ready, 64'(lq.size() < 4));
            chk("pend0", pend[0], 0);
            if (regWrite) begin
                if (exp_q.size() == 0) chk("wb_extra", regWrite, 0);
                else begin
                    e_c = exp_q.pop_front();
                    chk("wb_rd", write_reg, e_c.rd);
                    chk("wb_data", write_data, e_c.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        {alu_valid, lu_valid, iss_valid} = '0;
        {alu_rd, lu_rd, iss_rd, chk_rs1, chk_rs2, chk_rd} = '0;
        alu_data = '0;
        lu_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_regWrite", regWrite, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_pend", pend, 0);
        chk("rst_lu_ready", lu_ready, 0);
        #2 rst = 1'b0;
        #1 chk("post_rst_lu_ready", lu_ready, 1);

        // ALU single write
        @(negedge clk);
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
        @(negedge clk);
        alu_valid = 0;
        chk("alu_we", regWrite, 1);
        chk("alu_reg", write_reg, 5);
        chk("alu_data", write_data, 32'h1234);
        @(negedge clk);
        chk("alu_we_off", regWrite, 0);

        // scoreboard set, LU write-back latency and clear
        iss_valid = 1; iss_rd = 7; chk_rs1 = 7;
        @(negedge clk);
        iss_valid = 0;
        #1 chk("pend7_set", pend[7], 1);
        chk("stall7", stall, 1);
        chk("lu_ready_idle", lu_ready, 1);
        lu_valid = 1; lu_rd = 7; lu_data = 32'hCAFE;
        @(negedge clk);
        lu_valid = 0;
        chk("lu_t1_we", regWrite, 0);
        chk("lu_t1_pend7", pend[7], 1);
        @(negedge clk);
        chk("lu_t2_we", regWrite, 1);
        chk("lu_t2_reg", write_reg, 7);
        chk("lu_t2_data", write_data, 32'hCAFE);
        chk("lu_t2_pend7", pend[7], 0);
        chk("lu_t2_stall", stall, 0);
        chk_rs1 = 0;

        // backpressure while ALU is busy every cycle
        k = 0;
        for (int c = 0; c < 6; c++) begin
            alu_valid = 1; alu_rd = 5'(10 + c); alu_data = 32'h100 + c;
            lu_valid = k < 5; lu_rd = 5'(20 + k); lu_data = 32'h200 + k;
            acc = lu_valid && lu_ready;
            @(negedge clk);
            if (acc) k++;
        end
        chk("bp_accepted", k, 4);
        chk("bp_full_ready", lu_ready, 0);
        alu_valid = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            lu_valid = 1; lu_rd = 5'(20 + k); lu_data = 32'h200 + k;
            acc = lu_ready;
            @(negedge clk);
            if (acc) k++;
        end
        lu_valid = 0;
        chk("bp_all_accepted", k, 5);
        repeat (8) @(negedge clk);
        chk("bp_drained", exp_q.size(), 0);

        // x0 destinations from both sources
        for (int c = 0; c < 4; c++) begin
            alu_valid = 1; alu_rd = 0; alu_data = 32'hFF;
            lu_valid = 1; lu_rd = 0; lu_data = 32'hEE;
            iss_valid = 1; iss_rd = 0;
            @(negedge clk);
        end
        {alu_valid, lu_valid, iss_valid} = '0;
        chk("x0_full", lu_ready, 0);
        chk("x0_pend", pend, 0);
        @(negedge clk);
        chk("x0_pop_frees", lu_ready, 1);
        for (int c = 0; c < 4; c++) begin
            chk("x0_no_we", regWrite, 0);
            @(negedge clk);
        end

        // pop and issue of the same register in one cycle
        iss_valid = 1; iss_rd = 9;
        @(negedge clk);
        iss_valid = 0;
        lu_valid = 1; lu_rd = 9; lu_data = 32'h99;
        @(negedge clk);
        lu_valid = 0;
        iss_valid = 1; iss_rd = 9;
        @(negedge clk);
        iss_valid = 0;
        chk("same_we", regWrite, 1);
        chk("same_reg", write_reg, 9);
        chk("same_pend9", pend[9], 1);

        // reset with buffered entries and pending bits
        iss_valid = 1; iss_rd = 3;
        for (int c = 0; c < 3; c++) begin
            alu_valid = 1; alu_rd = 5'(12 + c); alu_data = 32'h300 + c;
            lu_valid = 1; lu_rd = 5'(3 + c); lu_data = 32'h400 + c;
            @(negedge clk);
            iss_valid = 0;
        end
        chk("pre_rst_pend", pend[3] && pend[9], 1);
        #2 rst = 1'b1;
        {alu_valid, lu_valid, iss_valid} = '0;
        #1 chk("rst_mid_pend", pend, 0);
        chk("rst_mid_we", regWrite, 0);
        chk("rst_mid_ready", lu_ready, 0);
        @(negedge clk);
        chk("rst_hold_ready", lu_ready, 0);
        chk("rst_hold_reg", write_reg, 0);
        #2 rst = 1'b0;
        #1 chk("rel_ready", lu_ready, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("rel_no_we", regWrite, 0);
        end
        chk("final_exp_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
